// File: rtl/coco_keymatrix_if.sv
// Keyboard/PIA0 side signals of the CoCo key matrix, grouped so the host
// (PS/2 source and column scanner) and the matrix block share one bundle.
interface coco_keymatrix_if;
   logic [10:0] ps2_key;
   logic [7:0]  col_n;
   logic [6:0]  row_n;
   logic        key_any;
   logic [55:0] matrix_dbg;

   modport master (
      output ps2_key,
      output col_n,
      input  row_n,
      input  key_any,
      input  matrix_dbg
   );

   modport slave (
      input  ps2_key,
      input  col_n,
      output row_n,
      output key_any,
      output matrix_dbg
   );
endinterface

// File: rtl/coco_keymatrix.sv
// Turns hps_io ps2_key events into the 7x8 CoCo2 keyboard matrix scanned by
// PIA0, stretching short taps so slow software scans still see them.
module coco_keymatrix #(
   parameter int                HOLD_W   = 20,
   parameter logic [HOLD_W-1:0] MIN_HOLD = HOLD_W'(833333)
) (
   input logic             clk_sys,
   input logic             reset,
   coco_keymatrix_if.slave bus
);

   logic              tog_q;
   logic [55:0]       matrix;
   logic [55:0]       matrix_nxt;
   logic [5:0]        last_idx;
   logic [5:0]        last_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              pend;
   logic              pend_nxt;
   logic [6:0]        row_q;
   logic [6:0]        row_nxt;
   logic              any_q;

   logic              evt;
   logic              press;
   logic              hold_expiring;
   logic [6:0]        key_map;
   logic              key_valid;
   logic [5:0]        key_idx;

   assign evt   = bus.ps2_key[10] != tog_q;
   assign press = bus.ps2_key[9];

   // Each entry is octal {valid, row, col}, so the matrix bit is {row, col}.
   always_comb begin
      key_map = 7'o000;
      unique case (bus.ps2_key[8:0])
         9'h054: key_map = 7'o100;
         9'h01C: key_map = 7'o101;
         9'h032: key_map = 7'o102;
         9'h021: key_map = 7'o103;
         9'h023: key_map = 7'o104;
         9'h024: key_map = 7'o105;
         9'h02B: key_map = 7'o106;
         9'h034: key_map = 7'o107;
         9'h033: key_map = 7'o110;
         9'h043: key_map = 7'o111;
         9'h03B: key_map = 7'o112;
         9'h042: key_map = 7'o113;
         9'h04B: key_map = 7'o114;
         9'h03A: key_map = 7'o115;
         9'h031: key_map = 7'o116;
         9'h044: key_map = 7'o117;
         9'h04D: key_map = 7'o120;
         9'h015: key_map = 7'o121;
         9'h02D: key_map = 7'o122;
         9'h01B: key_map = 7'o123;
         9'h02C: key_map = 7'o124;
         9'h03C: key_map = 7'o125;
         9'h02A: key_map = 7'o126;
         9'h01D: key_map = 7'o127;
         9'h022: key_map = 7'o130;
         9'h035: key_map = 7'o131;
         9'h01A: key_map = 7'o132;
         9'h175: key_map = 7'o133;
         9'h172: key_map = 7'o134;
         9'h16B: key_map = 7'o135;
         9'h174: key_map = 7'o136;
         9'h029: key_map = 7'o137;
         9'h045: key_map = 7'o140;
         9'h016: key_map = 7'o141;
         9'h01E: key_map = 7'o142;
         9'h026: key_map = 7'o143;
         9'h025: key_map = 7'o144;
         9'h02E: key_map = 7'o145;
         9'h036: key_map = 7'o146;
         9'h03D: key_map = 7'o147;
         9'h03E: key_map = 7'o150;
         9'h046: key_map = 7'o151;
         9'h052: key_map = 7'o152;
         9'h04C: key_map = 7'o153;
         9'h041: key_map = 7'o154;
         9'h04E: key_map = 7'o155;
         9'h049: key_map = 7'o156;
         9'h04A: key_map = 7'o157;
         9'h05A: key_map = 7'o160;
         9'h16C: key_map = 7'o161;
         9'h076: key_map = 7'o162;
         9'h011: key_map = 7'o163;
         9'h014: key_map = 7'o164;
         9'h005: key_map = 7'o165;
         9'h006: key_map = 7'o166;
         9'h012: key_map = 7'o167;
         9'h059: key_map = 7'o167;
         default: key_map = 7'o000;
      endcase
   end

   assign key_valid = key_map[6];
   assign key_idx   = key_map[5:0];

   // True when the counter is at 0 now or reaches 0 at this edge.
   assign hold_expiring = (hold_cnt[HOLD_W-1:1] == '0);

   // Events take priority; a deferred release then fires on the edge where
   // the hold counter runs out.
   always_comb begin
      matrix_nxt = matrix;
      last_nxt   = last_idx;
      pend_nxt   = pend;
      hold_nxt   = (hold_cnt != '0) ? hold_cnt - HOLD_W'(1) : '0;

      if (evt && key_valid) begin
         if (press) begin
            if (pend && (last_idx != key_idx)) begin
               matrix_nxt[last_idx] = 1'b0;
            end
            pend_nxt            = 1'b0;
            matrix_nxt[key_idx] = 1'b1;
            last_nxt            = key_idx;
            hold_nxt            = MIN_HOLD;
         end else if ((key_idx != last_idx) || hold_expiring) begin
            matrix_nxt[key_idx] = 1'b0;
         end else if (matrix[key_idx]) begin
            pend_nxt = 1'b1;
         end
      end

      if (pend_nxt && hold_expiring) begin
         matrix_nxt[last_idx] = 1'b0;
         pend_nxt             = 1'b0;
      end
   end

   always_comb begin
      row_nxt = '1;
      for (int r = 0; r < 7; r++) begin
         row_nxt[r] = ~|(matrix[r*8 +: 8] & ~bus.col_n);
      end
   end

   always_ff @(posedge clk_sys) begin
      tog_q <= bus.ps2_key[10];
      if (reset) begin
         matrix   <= '0;
         last_idx <= '0;
         hold_cnt <= '0;
         pend     <= 1'b0;
         row_q    <= 7'h7F;
         any_q    <= 1'b0;
      end else begin
         matrix   <= matrix_nxt;
         last_idx <= last_nxt;
         hold_cnt <= hold_nxt;
         pend     <= pend_nxt;
         row_q    <= row_nxt;
         any_q    <= |matrix;
      end
   end

   assign bus.row_n      = row_q;
   assign bus.key_any    = any_q;
   assign bus.matrix_dbg = matrix;

endmodule

// File: tb/tb_coco_keymatrix.sv
// Scoreboard bench for coco_keymatrix: one instance with a 1000-cycle hold and
// one with stretching disabled, both fed the same PS/2 events and column scans.
module tb_coco_keymatrix;

   localparam int HOLD_A = 1000;

   typedef struct {
      bit [55:0] mat_a;
      bit [55:0] mat_b;
      bit [6:0]  row_a;
      bit [6:0]  row_b;
      bit        any_a;
      bit        any_b;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic [10:0] ps2     = 11'h400;
   logic [7:0]  col     = 8'hFF;

   coco_keymatrix_if bus_a ();
   coco_keymatrix_if bus_b ();

   assign bus_a.ps2_key = ps2;
   assign bus_a.col_n   = col;
   assign bus_b.ps2_key = ps2;
   assign bus_b.col_n   = col;

   coco_keymatrix #(.HOLD_W(20), .MIN_HOLD(20'd1000)) dut_a (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus_a)
   );

   coco_keymatrix #(.HOLD_W(20), .MIN_HOLD(20'd0)) dut_b (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus_b)
   );

   always #5 clk_sys = ~clk_sys;

   int        n_tests = 0;
   int        n_fail  = 0;
   exp_t      sb_q[$];
   int        keymap[bit [8:0]];
   bit [8:0]  pool[$];

   // Reference state: a matrix image, the last pressed key, and the absolute
   // cycle at which that key's minimum hold ends.
   bit [55:0] m_mat[2];
   int        m_last[2];
   bit        m_pend[2];
   longint    m_dead[2];
   int        hold_of[2] = '{HOLD_A, 0};
   bit        m_tog = 1'b0;
   longint    cyc = 0;

   function automatic void add_key(bit [8:0] code, int row, int c);
      keymap[code] = row * 8 + c;
   endfunction

   function automatic bit [6:0] exp_rows(bit [55:0] m, bit [7:0] cn);
      bit [6:0] res = 7'h7F;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 8; c++)
            if (m[r*8+c] && !cn[c]) res[r] = 1'b0;
      return res;
   endfunction

   function automatic void model_event(int i, bit pr, int idx);
      if (pr) begin
         if (m_pend[i] && m_last[i] != idx) m_mat[i][m_last[i]] = 1'b0;
         m_pend[i]     = 1'b0;
         m_mat[i][idx] = 1'b1;
         m_last[i]     = idx;
         m_dead[i]     = cyc + hold_of[i];
      end else if (idx != m_last[i] || cyc >= m_dead[i]) begin
         m_mat[i][idx] = 1'b0;
      end else if (m_mat[i][idx]) begin
         m_pend[i] = 1'b1;
      end
   endfunction

   function automatic bit [7:0] rand_col();
      case ($urandom_range(0, 2))
         0: return 8'hFF;
         1: return ~(8'h01 << $urandom_range(0, 7));
         default: return 8'($urandom);
      endcase
   endfunction

   // One clock of stimulus: drive inputs, advance the model, queue the
   // outputs expected just after the coming edge.
   task automatic apply_stimulus(input bit rst, input bit tg, input bit pr,
                                 input bit [8:0] code, input bit [7:0] cn);
      exp_t e;
      bit   ev;
      @(negedge clk_sys);
      reset = rst;
      if (tg) ps2 = {~ps2[10], pr, code};
      col = cn;
      if (rst) begin
         e.row_a = 7'h7F;
         e.row_b = 7'h7F;
         e.any_a = 1'b0;
         e.any_b = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_mat[i]  = '0;
            m_last[i] = 0;
            m_pend[i] = 1'b0;
            m_dead[i] = 0;
         end
         m_tog = ps2[10];
      end else begin
         e.row_a = exp_rows(m_mat[0], cn);
         e.row_b = exp_rows(m_mat[1], cn);
         e.any_a = |m_mat[0];
         e.any_b = |m_mat[1];
         ev      = (ps2[10] != m_tog);
         m_tog   = ps2[10];
         for (int i = 0; i < 2; i++) begin
            if (ev && keymap.exists(ps2[8:0])) model_event(i, ps2[9], keymap[ps2[8:0]]);
            if (m_pend[i] && cyc >= m_dead[i]) begin
               m_mat[i][m_last[i]] = 1'b0;
               m_pend[i]           = 1'b0;
            end
         end
      end
      e.mat_a = m_mat[0];
      e.mat_b = m_mat[1];
      sb_q.push_back(e);
      cyc++;
   endtask

   task automatic key(input bit pr, input bit [8:0] code, input bit [7:0] cn);
      apply_stimulus(1'b0, 1'b1, pr, code, cn);
   endtask

   task automatic idle(input int n, input bit [7:0] cn);
      for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 9'h000, cn);
   endtask

   task automatic check_output(input string name, input logic [55:0] act,
                               input logic [55:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Monitor: every edge that has a queued expectation is checked 1 ns later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_sys);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output("matrix_a", bus_a.matrix_dbg, e.mat_a);
            check_output("row_n_a",  56'(bus_a.row_n), 56'(e.row_a));
            check_output("any_a",    56'(bus_a.key_any), 56'(e.any_a));
            check_output("matrix_b", bus_b.matrix_dbg, e.mat_b);
            check_output("row_n_b",  56'(bus_b.row_n), 56'(e.row_b));
            check_output("any_b",    56'(bus_b.key_any), 56'(e.any_b));
         end
      end
   end

   initial begin
      bit       r_rst;
      bit       r_tg;
      bit       r_pr;
      bit [8:0] r_code;
      bit [8:0] last_code;
      int       dens;

      add_key(9'h054,0,0); add_key(9'h01C,0,1); add_key(9'h032,0,2); add_key(9'h021,0,3);
      add_key(9'h023,0,4); add_key(9'h024,0,5); add_key(9'h02B,0,6); add_key(9'h034,0,7);
      add_key(9'h033,1,0); add_key(9'h043,1,1); add_key(9'h03B,1,2); add_key(9'h042,1,3);
      add_key(9'h04B,1,4); add_key(9'h03A,1,5); add_key(9'h031,1,6); add_key(9'h044,1,7);
      add_key(9'h04D,2,0); add_key(9'h015,2,1); add_key(9'h02D,2,2); add_key(9'h01B,2,3);
      add_key(9'h02C,2,4); add_key(9'h03C,2,5); add_key(9'h02A,2,6); add_key(9'h01D,2,7);
      add_key(9'h022,3,0); add_key(9'h035,3,1); add_key(9'h01A,3,2); add_key(9'h175,3,3);
      add_key(9'h172,3,4); add_key(9'h16B,3,5); add_key(9'h174,3,6); add_key(9'h029,3,7);
      add_key(9'h045,4,0); add_key(9'h016,4,1); add_key(9'h01E,4,2); add_key(9'h026,4,3);
      add_key(9'h025,4,4); add_key(9'h02E,4,5); add_key(9'h036,4,6); add_key(9'h03D,4,7);
      add_key(9'h03E,5,0); add_key(9'h046,5,1); add_key(9'h052,5,2); add_key(9'h04C,5,3);
      add_key(9'h041,5,4); add_key(9'h04E,5,5); add_key(9'h049,5,6); add_key(9'h04A,5,7);
      add_key(9'h05A,6,0); add_key(9'h16C,6,1); add_key(9'h076,6,2); add_key(9'h011,6,3);
      add_key(9'h014,6,4); add_key(9'h005,6,5); add_key(9'h006,6,6); add_key(9'h012,6,7);
      add_key(9'h059,6,7);
      foreach (keymap[c]) pool.push_back(c);
      pool.push_back(9'h00D);
      pool.push_back(9'h075);
      pool.push_back(9'h11C);
      pool.push_back(9'h0FF);

      // Reset, then a long quiet stretch with bit10 held high.
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 9'h000, 8'hFF);
      for (int k = 0; k < 100; k++) idle(1, rand_col());

      // A on column 1, then the neighbouring column.
      key(1'b1, 9'h01C, 8'hFD);
      idle(3, 8'hFD);
      idle(2, 8'hFE);

      // Quick SPACE tap is stretched to the full hold.
      key(1'b1, 9'h029, 8'h7F);
      idle(9, 8'h7F);
      key(1'b0, 9'h029, 8'h7F);
      idle(1100, 8'h7F);

      // B tapped, H pressed while B's release is still pending.
      key(1'b1, 9'h032, 8'hFB);
      idle(9, 8'hFB);
      key(1'b0, 9'h032, 8'hFB);
      idle(9, 8'hFB);
      key(1'b1, 9'h033, 8'hFE);
      idle(1100, 8'hFE);

      // Both shifts share one bit; extended UP; TAB is unmapped.
      key(1'b1, 9'h012, 8'h7F);
      idle(5, 8'h7F);
      key(1'b1, 9'h059, 8'h7F);
      idle(1005, 8'h7F);
      key(1'b0, 9'h059, 8'h7F);
      idle(5, 8'h7F);
      key(1'b0, 9'h012, 8'h7F);
      idle(3, 8'h7F);
      key(1'b1, 9'h175, 8'hF7);
      idle(3, 8'hF7);
      key(1'b1, 9'h00D, 8'h00);
      idle(3, 8'h00);

      // Reset in the middle of ENTER's hold, then a stale release.
      key(1'b1, 9'h05A, 8'hFE);
      idle(5, 8'hFE);
      apply_stimulus(1'b1, 1'b0, 1'b0, 9'h000, 8'hFE);
      idle(3, 8'hFE);
      key(1'b0, 9'h05A, 8'hFE);
      idle(1100, 8'hFE);

      // Random traffic with occasional resets and long idle gaps.
      last_code = 9'h01C;
      for (int blk = 0; blk < 16; blk++) begin
         dens = $urandom_range(2, 8);
         for (int k = 0; k < 400; k++) begin
            r_rst  = ($urandom_range(0, 399) == 0);
            r_tg   = ($urandom_range(1, dens) == 1);
            r_pr   = 1'($urandom_range(0, 1));
            r_code = ($urandom_range(0, 2) == 0) ? last_code
                                                 : pool[$urandom_range(0, pool.size() - 1)];
            if (r_tg && r_pr) last_code = r_code;
            apply_stimulus(r_rst, r_tg, r_pr, r_code, rand_col());
         end
         if ($urandom_range(0, 2) == 0) idle(1100, rand_col());
      end
      idle(2, 8'h00);

      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk_sys);
      #2;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coco_keymatrix.md
Name: coco_keymatrix

Overview:
- Converts hps_io `ps2_key` events into the 7x8 CoCo2 keyboard matrix.
- The po8 core scans the matrix through its PIA0 column strobes (PB) and row returns (PA).
- Sits directly upstream of po8 and replaces its raw ps2_key decode.
- Guarantees a minimum press duration so quick taps are not missed by slow software scans.

Parameters:
- MIN_HOLD, 20'd833333: minimum cycles a press stays asserted in the matrix (about 16.7 ms at 50 MHz).
- HOLD_W, 20: width of the hold counter.

Ports:
- clk_sys  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] toggles on each event, [9] 1=press/0=release, [8] E0-extended, [7:0] scancode.
- col_n  in  8  PIA0 PB column strobes, active low.
- row_n  out  7  PIA0 PA row returns, active low, registered.
- key_any  out  1  1 when any matrix bit is set.
- matrix_dbg  out  56  raw matrix, bit index row*8+col, 1 = pressed.

Behaviour:
- Reset values:
  - matrix = 0, row_n = 7'h7F, key_any = 0.
  - Hold counter = 0, pending-release flag = 0.
  - The toggle register loads ps2_key[10], so no event is generated on reset release.
  - Reset mid-operation drops any pending release.
- Event detect:
  - An event fires in the cycle after ps2_key[10] differs from the toggle register; the register then updates.
  - Exactly one event is processed per toggle.
- Decode, combinational on {ps2_key[8], ps2_key[7:0]} to (row, col, valid):
  - Row 0: @ A B C D E F G.
  - Row 1: H I J K L M N O.
  - Row 2: P Q R S T U V W.
  - Row 3: X Y Z UP DOWN LEFT RIGHT SPACE.
  - Row 4: 0 1 2 3 4 5 6 7.
  - Row 5: 8 9 : ; , - . /.
  - Row 6: ENTER CLEAR BREAK ALT CTRL F1 F2 SHIFT.
  - Required codes:
    - A=1C→(0,1), B=32→(0,2), H=33→(1,0), SPACE=29→(3,7).
    - UP=E0 75→(3,3), LEFT=E0 6B→(3,5).
    - 0=45→(4,0), ENTER=5A→(6,0), HOME=E0 6C→CLEAR (6,1), ESC=76→BREAK (6,2).
    - LSHIFT=12 and RSHIFT=59 → both (6,7); shift is a single bit, released when either shift key releases.
    - '@' = 54 ('[' key).
  - Unmapped codes are ignored: no state change.
- Press event, valid:
  - Set matrix[row][col].
  - Latch {row, col} as the last key.
  - Hold counter = MIN_HOLD.
- Hold counter decrements each cycle while nonzero and saturates at 0.
- Release event, valid:
  - Key is not the last key, or counter = 0: clear the bit immediately.
  - Otherwise set the pending flag. When the counter reaches 0, clear the last key's bit and clear the pending flag in that same cycle.
- Simultaneous/overlap cases:
  - Press of the pending key while pending: cancel the pending flag, bit stays set, counter reloads.
  - Press of a different key while pending: clear the pending key's bit and set the new bit in the same cycle. The new key becomes the last key and the counter reloads.
  - Release of an already-clear bit: no-op.
- Scan output, 1-cycle latency from col_n or matrix change:
  - row_n[r] <= ~|(matrix[r] & ~col_n).
  - col_n = 8'hFF gives row_n = 7'h7F.
  - Multiple low columns OR together; ghosting is not modelled.
- key_any <= |matrix, registered.
- MIN_HOLD = 0 disables stretching: every release is immediate.

Test Plan:
- Reset, then hold ps2_key static with bit10 = 1 for 100 cycles → row_n = 7F throughout, matrix_dbg = 0, no event.
- Press A (toggle, 0x21C), then col_n = FD → row_n = 7E two cycles after the toggle. With col_n = FE → row_n = 7F.
- Press SPACE, release after 10 cycles, MIN_HOLD = 1000 → bit (3,7) stays set until exactly 1000 cycles after the press, then clears; row_n[3] returns to 1 with col_n = 7F.
- Press B, release B at 10 cycles, press H at 20 cycles → at the H event cycle, bit (0,2) clears and (1,0) sets in the same cycle.
- Press LSHIFT, press RSHIFT, release RSHIFT after MIN_HOLD → bit (6,7) clears. Press E0 75 → (3,3) set. Scancode 0x0D (TAB) → no change.
- Press ENTER, assert reset for 1 cycle mid-hold → next cycle matrix = 0, row_n = 7F, pending cleared. A later release event is a no-op.
